// File: rtl/mux_nto1_stream_if.sv
// mux_nto1_stream_if: N-channel input bundle, select controls and output stream.
//   in_data/in_valid/in_ready : N source streams (channel i at [i*WIDTH +: WIDTH])
//   sel/sel_load/mode/cur_sel : select control and current pointer
//   out_data/out_valid/out_ready : merged output stream
`timescale 1ns/1ps
interface mux_nto1_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic               sel_load;
    logic               mode;
    logic [SELW-1:0]    cur_sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;

    // Environment side: drives sources, control and downstream ready
    modport master (
        output in_data, in_valid, sel, sel_load, mode, out_ready,
        input  in_ready, cur_sel, out_data, out_valid
    );

    // Mux side
    modport slave (
        input  in_data, in_valid, sel, sel_load, mode, out_ready,
        output in_ready, cur_sel, out_data, out_valid
    );
endinterface

// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N:1 WIDTH-bit stream mux with a one-entry registered output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_nto1_stream_if.slave (sources, select control, output stream)
// Fixed mode routes channel cur_sel; round-robin mode picks the first valid
// channel at or after cur_sel and advances the pointer past it on each accept.
`timescale 1ns/1ps
module mux_nto1_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_nto1_stream_if.slave  bus
);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    logic [SELW-1:0]  cur_sel_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SELW-1:0]  ch_c;
    logic             space_c;
    logic             acc_c;
    logic [N-1:0]     in_ready_c;
    logic [WIDTH-1:0] sel_data_c;

    // Channel choice: cur_sel, or first valid channel scanning up from cur_sel with wrap
    always_comb begin
        logic            found;
        logic [SELW-1:0] idx;
        ch_c  = cur_sel_q;
        found = 1'b0;
        idx   = cur_sel_q;
        if (bus.mode) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!found && bus.in_valid[idx]) begin
                    ch_c  = idx;
                    found = 1'b1;
                end
                idx = (idx == LAST_CH) ? '0 : idx + SELW'(1);
            end
        end
    end

    // Handshake: only the chosen channel may be accepted, and only when the slot frees up
    always_comb begin
        space_c    = !out_valid_q || bus.out_ready;
        in_ready_c = (rst_n && space_c) ? (N'(1) << ch_c) : '0;
        acc_c      = bus.in_valid[ch_c] && in_ready_c[ch_c];
        sel_data_c = bus.in_data[32'(ch_c) * WIDTH +: WIDTH];
    end

    // Output register and select pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cur_sel_q   <= '0;
        end else begin
            if (acc_c) begin
                out_data_q  <= sel_data_c;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // An out-of-range load still blocks the round-robin advance
            if (bus.sel_load) begin
                if (32'(bus.sel) < N) begin
                    cur_sel_q <= bus.sel;
                end
            end else if (bus.mode && acc_c) begin
                cur_sel_q <= (ch_c == LAST_CH) ? '0 : ch_c + SELW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cur_sel   = cur_sel_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream: directed and random checks of mux_nto1_stream against a
// cycle-level reference model; a second N=3 instance covers out-of-range loads.
`timescale 1ns/1ps
module tb_mux_nto1_stream;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_nto1_stream_if #(.WIDTH(WIDTH), .N(N)) bus ();
    mux_nto1_stream #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mux_nto1_stream_if #(.WIDTH(WIDTH), .N(3)) bus3 ();
    mux_nto1_stream #(.WIDTH(WIDTH), .N(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    int n_tests;
    int n_fail;

    // Reference model state
    int unsigned      m_cur;
    logic             m_ov;
    logic [WIDTH-1:0] m_od;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0;
        m_ov  = 1'b0;
        m_od  = '0;
    endtask

    // Check DUT against model with current inputs, then advance one clock
    task automatic step();
        int unsigned      ch;
        logic             space;
        logic             acc;
        logic [N-1:0]     er;
        int unsigned      ncur;
        logic             nov;
        logic [WIDTH-1:0] nod;
        #1;
        ch = m_cur;
        if (bus.mode) begin
            // descending scan leaves the nearest valid channel at or after m_cur
            for (int k = N - 1; k >= 0; k--) begin
                if (bus.in_valid[(m_cur + 32'(k)) % N]) ch = (m_cur + 32'(k)) % N;
            end
        end
        space = !m_ov || bus.out_ready;
        er    = space ? (N'(1) << ch) : '0;
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("out_data",  32'(bus.out_data),  32'(m_od));
        check("cur_sel",   32'(bus.cur_sel),   m_cur);
        check("in_ready",  32'(bus.in_ready),  32'(er));
        acc  = space && bus.in_valid[ch];
        nod  = m_od;
        nov  = m_ov;
        ncur = m_cur;
        if (acc) begin
            nod = bus.in_data[ch*WIDTH +: WIDTH];
            nov = 1'b1;
        end else if (bus.out_ready) begin
            nov = 1'b0;
        end
        if (bus.sel_load) begin
            if (32'(bus.sel) < N) ncur = 32'(bus.sel);
        end else if (bus.mode && acc) begin
            ncur = (ch + 1) % N;
        end
        @(posedge clk);
        m_cur = ncur;
        m_ov  = nov;
        m_od  = nod;
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] bytes [4];
        int               rr_ch  [6];
        int               rr_cur [6];
        bytes  = '{8'h11, 8'h22, 8'h33, 8'h55};
        rr_ch  = '{0, 1, 3, 0, 1, 3};
        rr_cur = '{1, 2, 0, 1, 2, 0};
        n_tests = 0;
        n_fail  = 0;

        rst_n         = 1'b0;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.in_valid  = '1;
        bus.sel       = '0;
        bus.sel_load  = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        bus3.in_data   = '0;
        bus3.in_valid  = '0;
        bus3.sel       = '0;
        bus3.sel_load  = 1'b0;
        bus3.mode      = 1'b0;
        bus3.out_ready = 1'b1;

        // Reset state with all inputs valid
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_cur_sel",   32'(bus.cur_sel),   32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'h1);
        model_reset();

        // Fixed mode load sel=2; N=3 instance gets an out-of-range load
        bus.sel = 2'd2;  bus.sel_load = 1'b1;
        bus3.sel = 2'd3; bus3.sel_load = 1'b1;
        step();
        check("n3_sel3_ignored", 32'(bus3.cur_sel), 32'h0);
        bus.sel_load = 1'b0;
        bus3.sel = 2'd2;
        #1;
        check("sel2_in_ready", 32'(bus.in_ready), 32'h4);
        step();
        check("sel2_out_data",  32'(bus.out_data),  32'h33);
        check("sel2_out_valid", 32'(bus.out_valid), 32'h1);
        check("n3_sel2_loaded", 32'(bus3.cur_sel), 32'h2);
        bus3.sel = 2'd3;
        step();
        check("n3_sel3_holds", 32'(bus3.cur_sel), 32'h2);
        bus3.sel_load = 1'b0;

        // Fixed mode sweep
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s); bus.sel_load = 1'b1;
            step();
            bus.sel_load = 1'b0;
            step();
            check("sweep_data", 32'(bus.out_data), 32'(8'h11 * (s + 1)));
        end

        // Backpressure holds the output and closes every input
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready",  32'(bus.in_ready),  32'h0);
            check("bp_out_valid", 32'(bus.out_valid), 32'h1);
            check("bp_out_data",  32'(bus.out_data),  32'h44);
            step();
        end
        bus.in_data[31:24] = 8'h55;
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'h8);
        step();
        check("bp_release_data", 32'(bus.out_data), 32'h55);

        // Round robin over in_valid = 1011
        bus.sel = 2'd0; bus.sel_load = 1'b1;
        step();
        bus.sel_load = 1'b0;
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_data", 32'(bus.out_data), 32'(bytes[rr_ch[i]]));
            check("rr_cur",  32'(bus.cur_sel),  32'(rr_cur[i]));
        end

        // Load wins over round-robin advance in the same cycle
        bus.sel = 2'd3; bus.sel_load = 1'b1;
        step();
        check("load_over_rr_cur",  32'(bus.cur_sel),  32'h3);
        check("load_over_rr_data", 32'(bus.out_data), 32'h11);
        bus.sel_load = 1'b0;

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #0.5;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_out_data",  32'(bus.out_data),  32'h0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'h0);
        check("mid_rst_cur_sel",   32'(bus.cur_sel),   32'h0);
        #0.5;
        rst_n = 1'b1;
        model_reset();
        step();
        check("resume_ch0", 32'(bus.out_data), 32'h11);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = N'($urandom);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            bus.sel_load  = ($urandom_range(0, 9) == 0);
            bus.sel       = 2'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
